spi_master_mode: RTL
====================

SPI_MASTER_MODE -- requirements
Module: spi_master_mode

Interface
REQ-001 Parameter DATA_W, default 12, meaning bits per frame (legal 2..32).
REQ-002 Parameter CLK_DIV, default 10, meaning clk cycles per sclk half-period (legal >=1).
REQ-003 Parameter MSB_FIRST, default 0, meaning 1 = MSB shifted first, 0 = LSB first.
REQ-004 Port clk  input  1  meaning single system clock; all logic on its rising edge, and sclk is never used as a clock.
REQ-005 Port rst  input  1  meaning synchronous active-high reset.
REQ-006 Port newd  input  1  meaning start request; accepted only when busy=0.
REQ-007 Port din  input  DATA_W  meaning transmit word, captured on acceptance.
REQ-008 Port mode  input  2  meaning {CPOL,CPHA}, captured on acceptance.
REQ-009 Port miso  input  1  meaning serial data from the slave.
REQ-010 Port sclk  output  1  meaning serial clock.
REQ-011 Port cs  output  1  meaning active-low chip select.
REQ-012 Port mosi  output  1  meaning serial data to the slave.
REQ-013 Port dout  output  DATA_W  meaning received word, valid from done onward until the next acceptance.
REQ-014 Port busy  output  1  meaning a frame is in progress.
REQ-015 Port done  output  1  meaning one-cycle frame-complete pulse.

Function
REQ-016 States: IDLE, XFER, TRAIL; XFER is entered from IDLE when newd=1.
REQ-017 In the acceptance cycle, the block latches din and mode, and cs, busy and mosi update on the next edge.
REQ-018 Call the cycle after acceptance T0: cs=0, busy=1, and the first data bit is on mosi at T0.
REQ-019 sclk idles at the captured CPOL and toggles at T0+k*CLK_DIV for k=1..2*DATA_W; the odd k are leading edges.
REQ-020 CPHA=0: miso is sampled on each leading edge and mosi advances on each trailing edge, except after the final one.
REQ-021 CPHA=1: mosi advances on each leading edge, except the first, which presents bit 0 unchanged; miso is sampled on each trailing edge.
REQ-022 Bit order follows MSB_FIRST for both mosi and the dout assembly.
REQ-023 After edge 2*DATA_W, the block enters TRAIL for CLK_DIV cycles.
REQ-024 At T0+(2*DATA_W+1)*CLK_DIV, the block sets cs=1, busy=0, done=1 for one cycle, dout=received word, and mosi=0.
REQ-025 The state returns to IDLE at the same edge as REQ-024.
REQ-026 newd while busy=1 is ignored and is not queued.
REQ-027 newd in the cycle done=1 is accepted, because busy=0 in that cycle; back-to-back frames keep cs high for exactly one cycle.
REQ-028 Changes to din, mode or miso-independent inputs mid-frame have no effect on the frame.
REQ-029 The divider counter wraps from CLK_DIV-1 to 0 and runs only while busy=1.

Reset
REQ-030 On rst=1, outputs are: cs=1, sclk=0, mosi=0, busy=0, done=0, dout=0; state=IDLE; counters=0.
REQ-031 A reset mid-frame aborts the frame at the next clk edge, with no done pulse and dout cleared.
REQ-032 After reset the captured mode is 2'b00, so sclk idles low until the next acceptance.
REQ-033 A frame whose captured CPOL=1 drives sclk=1 in IDLE after completion.

Configuration
REQ-034 Macro SPI_MASTER_LOOPBACK_EN: when defined, the internal sample path uses mosi instead of miso, so dout equals din after a frame, and the miso port is ignored.
REQ-035 When SPI_MASTER_LOOPBACK_EN is undefined, the block samples miso per REQ-020/021.

Structure
REQ-036 Package spi_pkg holds the state enum (IDLE/XFER/TRAIL) and the typedef spi_mode_t {cpol,cpha}.
REQ-037 Sub-module spi_clkgen holds the divider counter, the edge counter, and the leading/trailing edge strobes.
REQ-038 The top module holds the FSM, shift registers and outputs.

Verification
REQ-039 DATA_W=12, CLK_DIV=2, MSB_FIRST=0, mode=00, din=12'hA5C, slave returns 12'h3C1: mosi bits are LSB-first, dout=12'h3C1, and done occurs at T0+50 cycles.
REQ-040 Same transfer with modes 01, 10 and 11: each edge is checked against REQ-020/021, sclk idles at CPOL, and dout=12'h3C1 in all four modes.
REQ-041 MSB_FIRST=1, DATA_W=8, din=8'h81, slave returns 8'h7E: the first mosi bit is 1, and dout=8'h7E.
REQ-042 newd pulsed at T0+5 mid-frame, then again in the done cycle: the first pulse is ignored, the second frame starts, and cs is high for exactly one cycle.
REQ-043 rst asserted at T0+13: at the next edge cs=1, busy=0, dout=0, no done pulse, and a following frame completes normally.
REQ-044 With SPI_MASTER_LOOPBACK_EN defined, din=12'h5A3 and miso held at 0: dout=12'h5A3.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM state encoding and the captured {CPOL,CPHA} mode.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        TRAIL = 2'd2
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/spi_clkgen.sv
// SPI bit-clock timing: divider counter, sclk edge counter and leading/trailing edge strobes.
module spi_clkgen #(
    parameter int DATA_W  = 12,
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic xfer,
    output logic tick,
    output logic lead,
    output logic trail,
    output logic first_edge,
    output logic last_edge
);

    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);

    logic [DIV_W-1:0]  div_cnt;
    logic [EDGE_W-1:0] edge_cnt;

    // tick marks the last clk of a half-period; the sclk edge becomes visible one clk later
    assign tick = en && (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || !en || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !xfer) begin
            edge_cnt <= '0;
        end else if (tick) begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

    // edge_cnt holds completed edges, so an even count means the coming edge is a leading one
    assign lead       = xfer && tick && !edge_cnt[0];
    assign trail      = xfer && tick && edge_cnt[0];
    assign first_edge = (edge_cnt == '0);
    assign last_edge  = (edge_cnt == EDGE_W'(2 * DATA_W - 1));

endmodule

// File: rtl/spi_master_mode.sv
// SPI master with run-time selectable mode {CPOL,CPHA}; sclk is a divided data signal.
// Optional macro SPI_MASTER_LOOPBACK_EN samples mosi instead of miso.
module spi_master_mode
    import spi_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int CLK_DIV   = 10,
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              newd,
    input  logic [DATA_W-1:0] din,
    input  logic [1:0]        mode,
    input  logic              miso,
    output logic              sclk,
    output logic              cs,
    output logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              busy,
    output logic              done
);

    spi_state_t        state, state_next;
    spi_mode_t         mode_q;
    logic [DATA_W-1:0] tx_sr, rx_sr;
    logic              xfer, tick, lead, trail, first_edge, last_edge;
    logic              accept, advance, sample, finish, in_bit;

    assign xfer = (state == XFER);
    assign busy = (state != IDLE);
    assign cs   = ~busy;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso;
    assign in_bit      = mosi;
`else
    assign in_bit = miso;
`endif

    spi_clkgen #(
        .DATA_W (DATA_W),
        .CLK_DIV(CLK_DIV)
    ) u_clkgen (
        .clk       (clk),
        .rst       (rst),
        .en        (busy),
        .xfer      (xfer),
        .tick      (tick),
        .lead      (lead),
        .trail     (trail),
        .first_edge(first_edge),
        .last_edge (last_edge)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (newd) state_next = XFER;
            XFER:    if (trail && last_edge) state_next = TRAIL;
            TRAIL:   if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept = (state == IDLE) && newd;
        finish = (state == TRAIL) && tick;
        // CPHA=1 keeps bit 0 through the first leading edge; CPHA=0 holds the last bit past the final edge
        if (mode_q.cpha) begin
            advance = lead && !first_edge;
            sample  = trail;
        end else begin
            advance = trail && !last_edge;
            sample  = lead;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk   <= 1'b0;
            mosi   <= 1'b0;
            done   <= 1'b0;
            dout   <= '0;
            mode_q <= '0;
        end else begin
            done <= finish;
            if (accept) begin
                mode_q <= spi_mode_t'(mode);
                sclk   <= mode[1];
                mosi   <= (MSB_FIRST != 0) ? din[DATA_W-1] : din[0];
            end else if (xfer && tick) begin
                sclk <= ~sclk;
            end
            if (advance) begin
                mosi <= (MSB_FIRST != 0) ? tx_sr[DATA_W-1] : tx_sr[0];
            end
            if (finish) begin
                mosi <= 1'b0;
                dout <= rx_sr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tx_sr <= (MSB_FIRST != 0) ? (din << 1) : (din >> 1);
        end else if (advance) begin
            tx_sr <= (MSB_FIRST != 0) ? (tx_sr << 1) : (tx_sr >> 1);
        end
        if (sample) begin
            rx_sr <= (MSB_FIRST != 0) ? {rx_sr[DATA_W-2:0], in_bit}
                                      : {in_bit, rx_sr[DATA_W-1:1]};
        end
    end

endmodule
